// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one block-level data memory between the instruction
// cache (read-only) and the data cache (read/write); one transaction at a time.
module mem_arbiter #(
  parameter int FIXED_PRI = 0,
  parameter int TIMEOUT   = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        I_READ,
  input  logic [5:0]  I_ADDRESS,
  output logic [31:0] I_READDATA,
  output logic        I_BUSYWAIT,
  input  logic        D_READ,
  input  logic        D_WRITE,
  input  logic [5:0]  D_ADDRESS,
  input  logic [31:0] D_WRITEDATA,
  output logic [31:0] D_READDATA,
  output logic        D_BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT,
  output logic        TIMEOUT_ERR
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BUSY_I = 3'd1;
  localparam logic [2:0] S_BUSY_D = 3'd2;
  localparam logic [2:0] S_RESP_I = 3'd3;
  localparam logic [2:0] S_RESP_D = 3'd4;
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);
  localparam logic       FIXED    = (FIXED_PRI != 0);

  logic [2:0] state, state_nxt;
  logic       last_d;
  logic [7:0] wdog, wdog_inc;
  logic       i_req, d_req;
  logic       grant_i, grant_d;
  logic       in_busy, first_busy, done, abort;

  assign i_req = I_READ;
  assign d_req = D_READ | D_WRITE;

  // D takes a tie under fixed priority, or whenever I held the previous grant.
  assign grant_d = (state == S_IDLE) && d_req && (!i_req || FIXED || !last_d);
  assign grant_i = (state == S_IDLE) && i_req && !grant_d;

  // The first BUSY cycle is blind to MEM_BUSYWAIT: a memory that raises it
  // combinationally off our strobe would otherwise look finished at once.
  assign in_busy    = (state == S_BUSY_I) || (state == S_BUSY_D);
  assign first_busy = (wdog == 8'd0);
  assign wdog_inc   = wdog + 8'd1;
  assign done       = in_busy && !first_busy && !MEM_BUSYWAIT;
  assign abort      = in_busy && !done && (wdog_inc == WD_LIMIT);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (grant_d)      state_nxt = S_BUSY_D;
        else if (grant_i) state_nxt = S_BUSY_I;
      end
      S_BUSY_I: if (done || abort) state_nxt = S_RESP_I;
      S_BUSY_D: if (done || abort) state_nxt = S_RESP_D;
      S_RESP_I: state_nxt = S_IDLE;
      S_RESP_D: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state  <= S_IDLE;
      last_d <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_d)      last_d <= 1'b1;
      else if (grant_i) last_d <= 1'b0;
    end
  end

  // Illegal D_READ & D_WRITE falls out as a write: MEM_READ is !D_WRITE.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= 6'd0;
      MEM_WRITEDATA <= 32'd0;
    end else if (grant_d) begin
      MEM_ADDRESS   <= D_ADDRESS;
      MEM_WRITEDATA <= D_WRITEDATA;
      MEM_WRITE     <= D_WRITE;
      MEM_READ      <= !D_WRITE;
    end else if (grant_i) begin
      MEM_ADDRESS   <= I_ADDRESS;
      MEM_READ      <= 1'b1;
      MEM_WRITE     <= 1'b0;
    end else if (done || abort) begin
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      I_READDATA <= 32'd0;
      D_READDATA <= 32'd0;
    end else if (done && MEM_READ) begin
      if (state == S_BUSY_I) I_READDATA <= MEM_READDATA;
      else                   D_READDATA <= MEM_READDATA;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wdog        <= 8'd0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      TIMEOUT_ERR <= abort;
      if (grant_i || grant_d || done || abort) wdog <= 8'd0;
      else if (in_busy)                        wdog <= wdog_inc;
    end
  end

  // A requester is released only in its own RESP cycle.
  assign I_BUSYWAIT = i_req & (state != S_RESP_I);
  assign D_BUSYWAIT = d_req & (state != S_RESP_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (round-robin and fixed priority), each
// with its own behavioural memory, directed cases plus a randomized model run.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        i_read [2], d_read [2], d_write [2];
  logic [5:0]  i_addr [2], d_addr [2], m_addr [2];
  logic [31:0] d_wdata [2], i_rdata [2], d_rdata [2], m_wdata [2], m_rdata [2];
  logic        i_bw [2], d_bw [2], m_rd [2], m_wr [2], m_bw [2], t_err [2];

  logic [31:0] mem [2][64];
  logic [31:0] ref_mem [2][64];
  int          mcnt [2];
  int          mlat [2];
  bit          stuck [2];
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [31:0] init_word(int a);
    return (a == 5) ? 32'hDEADBEEF : ((32'(a) * 32'h9E3779B1) ^ 32'h0BADF00D);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(.FIXED_PRI(g), .TIMEOUT(8)) dut (
      .CLK(clk), .RESET(rst_n),
      .I_READ(i_read[g]), .I_ADDRESS(i_addr[g]), .I_READDATA(i_rdata[g]), .I_BUSYWAIT(i_bw[g]),
      .D_READ(d_read[g]), .D_WRITE(d_write[g]), .D_ADDRESS(d_addr[g]), .D_WRITEDATA(d_wdata[g]),
      .D_READDATA(d_rdata[g]), .D_BUSYWAIT(d_bw[g]),
      .MEM_READ(m_rd[g]), .MEM_WRITE(m_wr[g]), .MEM_ADDRESS(m_addr[g]), .MEM_WRITEDATA(m_wdata[g]),
      .MEM_READDATA(m_rdata[g]), .MEM_BUSYWAIT(m_bw[g]), .TIMEOUT_ERR(t_err[g]));
    // Busy for mlat cycles after the strobe rises (or forever when stuck).
    assign m_bw[g]    = (m_rd[g] | m_wr[g]) & (stuck[g] | (mcnt[g] < mlat[g]));
    assign m_rdata[g] = mem[g][m_addr[g]];
  end

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        mcnt[g] <= 0;
        for (int a = 0; a < 64; a++) mem[g][a] <= init_word(a);
      end else if (m_rd[g] | m_wr[g]) begin
        if (m_wr[g] && !stuck[g] && mcnt[g] == mlat[g]) mem[g][m_addr[g]] <= m_wdata[g];
        mcnt[g] <= mcnt[g] + 1;
      end else begin
        mcnt[g] <= 0;
      end
    end
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr_inputs();
    for (int k = 0; k < 2; k++) begin
      i_read[k] = 1'b0; d_read[k] = 1'b0; d_write[k] = 1'b0;
      i_addr[k] = 6'd0; d_addr[k] = 6'd0; d_wdata[k] = 32'd0;
      mlat[k] = 0; stuck[k] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clr_inputs();
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 64; a++) ref_mem[k][a] = init_word(a);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // who: 1 = I released, 2 = D released, 3 = both (never legal), 0 = budget expired
  task automatic wait_resp(int k, int budget, output int who);
    int cyc = 0;
    who = 0;
    while (who == 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (i_read[k] && !i_bw[k]) who |= 1;
      if ((d_read[k] | d_write[k]) && !d_bw[k]) who |= 2;
    end
  endtask

  task automatic drain(int k);
    int n = 0;
    while ((m_rd[k] | m_wr[k]) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("drain%0d_strobes", k), 32'(m_rd[k] | m_wr[k]), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Both sides held: D,I alternate under round-robin, D repeats under fixed priority.
  task automatic tie_run(int k, int n_d);
    int last = 1;
    int exp_own, who;
    i_read[k] = 1'b1; i_addr[k] = 6'h10;
    d_read[k] = 1'b1; d_addr[k] = 6'h20;
    mlat[k] = 2;
    for (int t = 0; t < n_d; t++) begin
      exp_own = (k == 1 || last == 1) ? 2 : 1;
      wait_resp(k, 40, who);
      chk($sformatf("tie%0d_owner%0d", k, t), 32'(who), 32'(exp_own));
      if (who == 1) chk($sformatf("tie%0d_idata%0d", k, t), i_rdata[k], ref_mem[k][6'h10]);
      if (who == 2) chk($sformatf("tie%0d_ddata%0d", k, t), d_rdata[k], ref_mem[k][6'h20]);
      last = exp_own;
    end
    d_read[k] = 1'b0;
    wait_resp(k, 40, who);
    chk($sformatf("tie%0d_i_after_d", k), 32'(who), 32'd1);
    i_read[k] = 1'b0;
    drain(k);
  endtask

  task automatic d_write_case(logic [5:0] a, logic [31:0] dat, logic both, logic [31:0] dmod);
    int who;
    mlat[0] = 3;
    d_addr[0] = a; d_wdata[0] = dat; d_write[0] = 1'b1; d_read[0] = both;
    @(negedge clk);
    chk("wr_strobe_w", 32'(m_wr[0]), 32'd1);
    chk("wr_strobe_r", 32'(m_rd[0]), 32'd0);
    @(negedge clk);
    d_addr[0] = 6'h01; d_wdata[0] = 32'hFFFF_FFFF;
    wait_resp(0, 40, who);
    chk("wr_owner", 32'(who), 32'd2);
    chk("wr_rdata_hold", d_rdata[0], dmod);
    d_write[0] = 1'b0; d_read[0] = 1'b0;
    drain(0);
    chk("wr_mem_target", mem[0][a], dat);
    chk("wr_mem_other", mem[0][1], init_word(1));
  endtask

  task automatic rand_run(int k, int n);
    int own_q [$];
    int last = 1;
    logic prev_s = 1'b0;
    logic [31:0] dmod = 32'd0;
    bit di = 1'b0, dd = 1'b0;
    fork
      begin
        for (int t = 0; t < n; t++) begin
          int w;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          i_addr[k] = 6'($urandom); i_read[k] = 1'b1;
          w = 0;
          do begin @(negedge clk); w++; end while (i_bw[k] && w < 200);
          chk($sformatf("rnd%0d_i_wait", k), 32'(i_bw[k]), 32'd0);
          i_read[k] = 1'b0;
        end
        di = 1'b1;
      end
      begin
        for (int t = 0; t < n; t++) begin
          int w, op;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          op = $urandom_range(0, 2);
          d_addr[k] = 6'($urandom); d_wdata[k] = $urandom;
          d_read[k] = (op != 1); d_write[k] = (op != 0);
          w = 0;
          do begin @(negedge clk); w++; end while (d_bw[k] && w < 200);
          chk($sformatf("rnd%0d_d_wait", k), 32'(d_bw[k]), 32'd0);
          d_read[k] = 1'b0; d_write[k] = 1'b0;
        end
        dd = 1'b1;
      end
      begin
        while (!(di && dd)) begin
          logic s, ir, dr;
          int own, who;
          @(posedge clk);
          #1;
          s  = m_rd[k] | m_wr[k];
          ir = i_read[k];
          dr = d_read[k] | d_write[k];
          if (s && !prev_s) begin
            own = (dr && (!ir || k == 1 || last == 1)) ? 2 : 1;
            last = own;
            own_q.push_back(own);
            chk($sformatf("rnd%0d_addr", k), 32'(m_addr[k]), 32'(own == 2 ? d_addr[k] : i_addr[k]));
            chk($sformatf("rnd%0d_mwr", k), 32'(m_wr[k]), 32'(own == 2 && d_write[k]));
            chk($sformatf("rnd%0d_mrd", k), 32'(m_rd[k]), 32'(!(own == 2 && d_write[k])));
            if (own == 2 && d_write[k]) chk($sformatf("rnd%0d_wdata", k), m_wdata[k], d_wdata[k]);
            mlat[k] = $urandom_range(0, 5);
          end
          prev_s = s;
          who = ((ir && !i_bw[k]) ? 1 : 0) | ((dr && !d_bw[k]) ? 2 : 0);
          if (who != 0) begin
            chk($sformatf("rnd%0d_owner", k), 32'(who), 32'(own_q.size() > 0 ? own_q.pop_front() : 0));
            if (who == 1) chk($sformatf("rnd%0d_idata", k), i_rdata[k], ref_mem[k][i_addr[k]]);
            if (who == 2 && d_write[k]) begin
              ref_mem[k][d_addr[k]] = d_wdata[k];
              chk($sformatf("rnd%0d_dhold", k), d_rdata[k], dmod);
            end else if (who == 2) begin
              dmod = ref_mem[k][d_addr[k]];
              chk($sformatf("rnd%0d_ddata", k), d_rdata[k], dmod);
            end
          end
        end
      end
    join
    drain(k);
    for (int a = 0; a < 64; a++) chk($sformatf("rnd%0d_mem%0d", k, a), mem[k][a], ref_mem[k][a]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    int first, lows, pulses, who;
    rst_n = 1'b0;
    clr_inputs();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst%0d_mrd", k), 32'(m_rd[k]), 32'd0);
      chk($sformatf("rst%0d_mwr", k), 32'(m_wr[k]), 32'd0);
      chk($sformatf("rst%0d_maddr", k), 32'(m_addr[k]), 32'd0);
      chk($sformatf("rst%0d_mwdata", k), m_wdata[k], 32'd0);
      chk($sformatf("rst%0d_irdata", k), i_rdata[k], 32'd0);
      chk($sformatf("rst%0d_drdata", k), d_rdata[k], 32'd0);
      chk($sformatf("rst%0d_terr", k), 32'(t_err[k]), 32'd0);
    end

    // Single I read, 4-cycle memory: released 6 cycles after the request.
    do_reset();
    mlat[0] = 4; i_read[0] = 1'b1; i_addr[0] = 6'h05;
    first = 0; lows = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("lat_mrd", 32'(m_rd[0]), 32'd1);
        chk("lat_maddr", 32'(m_addr[0]), 32'h05);
      end
      if (!i_bw[0]) begin
        lows++;
        if (first == 0) begin
          first = c;
          chk("lat_idata", i_rdata[0], 32'hDEADBEEF);
        end
      end
    end
    chk("lat_first_low", 32'(first), 32'd6);
    chk("lat_low_count", 32'(lows), 32'd1);
    i_read[0] = 1'b0;
    drain(0);

    do_reset();
    tie_run(0, 4);
    do_reset();
    tie_run(1, 3);

    // Write-back with address/data disturbed mid-BUSY, then the illegal read+write.
    do_reset();
    d_write_case(6'h3F, 32'hA5A5_0F0F, 1'b0, 32'd0);
    d_write_case(6'h3E, 32'h1234_5678, 1'b1, 32'd0);

    // Memory never finishes: abort after 8 BUSY cycles, then pending I proceeds.
    do_reset();
    stuck[0] = 1'b1; d_read[0] = 1'b1; d_addr[0] = 6'h07;
    first = 0; pulses = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (t_err[0]) begin
        pulses++;
        if (first == 0) begin
          first = c;
          chk("to_strobes", 32'(m_rd[0] | m_wr[0]), 32'd0);
          chk("to_d_released", 32'(d_bw[0]), 32'd0);
          chk("to_drdata_hold", d_rdata[0], 32'd0);
          d_read[0] = 1'b0; stuck[0] = 1'b0; mlat[0] = 2;
        end
      end
      if (c == 1) begin i_read[0] = 1'b1; i_addr[0] = 6'h09; end
    end
    chk("to_first_pulse", 32'(first), 32'd9);
    chk("to_pulse_count", 32'(pulses), 32'd1);
    wait_resp(0, 40, who);
    chk("to_i_owner", 32'(who), 32'd1);
    chk("to_i_data", i_rdata[0], ref_mem[0][6'h09]);
    i_read[0] = 1'b0;
    drain(0);

    // Reset two cycles into a D write; held request restarts from the grant.
    do_reset();
    mlat[0] = 10; d_write[0] = 1'b1; d_addr[0] = 6'h22; d_wdata[0] = 32'hCAFE_F00D;
    repeat (2) @(negedge clk);
    chk("rmid_mwr_before", 32'(m_wr[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rmid_mwr_async", 32'(m_wr[0]), 32'd0);
    @(negedge clk);
    chk("rmid_dbw_follows", 32'(d_bw[0]), 32'd1);
    for (int a = 0; a < 64; a++) ref_mem[0][a] = init_word(a);
    rst_n = 1'b1; mlat[0] = 1;
    @(negedge clk);
    chk("rmid_regrant_w", 32'(m_wr[0]), 32'd1);
    chk("rmid_regrant_a", 32'(m_addr[0]), 32'h22);
    wait_resp(0, 40, who);
    chk("rmid_owner", 32'(who), 32'd2);
    d_write[0] = 1'b0;
    drain(0);
    chk("rmid_mem", mem[0][6'h22], 32'hCAFE_F00D);

    do_reset();
    rand_run(0, 30);
    do_reset();
    rand_run(1, 30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
